// File: rtl/serial_word_adder_if.sv
// Handshake and data bundle for serial_word_adder: operand input channel,
// result output channel and the busy status flag.
interface serial_word_adder_if #(
  parameter int NUM_BYTES = 4
);
  localparam int W = 8 * NUM_BYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_word_adder.sv
// Byte-serial W-bit adder: one 8-bit slice is reused once per byte, so a
// result appears NUM_BYTES cycles after the operands are accepted.
module serial_word_adder #(
  parameter int NUM_BYTES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_word_adder_if.slave sif
);
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [NUM_BYTES-1:0][7:0] word_t;

  state_e           state_q, state_d;
  word_t            a_q, a_d;
  word_t            b_q, b_d;
  word_t            sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [7:0]       slice_a;
  logic [7:0]       slice_b;
  logic [7:0]       slice_sum;
  logic             slice_co;

  // The single byte-slice adder shared by every byte position.
  always_comb begin : byte_slice
    slice_a = a_q[idx_q];
    slice_b = b_q[idx_q];
    {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + 9'(carry_q);
  end

  always_comb begin : next_state
    // NOTE: every _d takes its _q value first, so branches that do not
    // touch a signal hold it instead of inferring a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (sif.in_valid) begin
          a_d     = sif.a;
          b_d     = sif.b;
          carry_d = sif.cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        sum_d[idx_q] = slice_sum;
        carry_d      = slice_co;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_co;
          // Same-sign operands whose result sign differs overflowed.
          ovf_d   = (a_q[NUM_BYTES-1][7] == b_q[NUM_BYTES-1][7]) &&
                    (slice_sum[7] != a_q[NUM_BYTES-1][7]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (sif.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the operand registers are reset along with the rest so the whole
  // state lives in one async-reset block and nothing powers up as X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values computed above, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign sif.in_ready  = (state_q == IDLE);
  assign sif.out_valid = (state_q == DONE);
  assign sif.busy      = (state_q != IDLE);
  assign sif.sum       = sum_q;
  assign sif.cout      = cout_q;
  assign sif.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_word_adder.sv
// Bench for serial_word_adder: directed corner cases on a 4-byte instance,
// then a random soak on 4-byte and 2-byte instances against a reference model.
module tb_serial_word_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_word_adder_if #(.NUM_BYTES(4)) sif4 ();
  serial_word_adder_if #(.NUM_BYTES(2)) sif2 ();

  serial_word_adder #(.NUM_BYTES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif4)
  );

  serial_word_adder #(.NUM_BYTES(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif2)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, ovf, sum} from plain integer addition.
  function automatic logic [33:0] ref4(input logic [31:0] av, bv, input logic ci);
    logic [32:0] t;
    t = {1'b0, av} + {1'b0, bv} + 33'(ci);
    return {t[32], (av[31] == bv[31]) && (t[31] != av[31]), t[31:0]};
  endfunction

  function automatic logic [17:0] ref2(input logic [15:0] av, bv, input logic ci);
    logic [16:0] t;
    t = {1'b0, av} + {1'b0, bv} + 17'(ci);
    return {t[16], (av[15] == bv[15]) && (t[15] != av[15]), t[15:0]};
  endfunction

  task automatic scramble4();
    sif4.a        = $urandom;
    sif4.b        = $urandom;
    sif4.cin      = 1'($urandom_range(0, 1));
    sif4.in_valid = 1'($urandom_range(0, 1));
  endtask

  // One full transaction on the 4-byte instance, called at posedge+1 in IDLE.
  task automatic do_op4(input string tag, input logic [31:0] av, bv,
                        input logic ci, input logic [33:0] exp, input int hold);
    sif4.a        = av;
    sif4.b        = bv;
    sif4.cin      = ci;
    sif4.in_valid = 1'b1;
    check({tag, "/in_ready"}, sif4.in_ready, 1);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      scramble4();
      check($sformatf("%s/early_valid%0d", tag, k), sif4.out_valid, 0);
      check($sformatf("%s/busy%0d", tag, k), sif4.busy, 1);
      @(posedge clk); #1;
    end
    check({tag, "/out_valid"}, sif4.out_valid, 1);
    check({tag, "/result"}, {sif4.cout, sif4.ovf, sif4.sum}, exp);
    for (int k = 0; k < hold; k++) begin
      scramble4();
      @(posedge clk); #1;
      check($sformatf("%s/hold_res%0d", tag, k),
            {sif4.cout, sif4.ovf, sif4.sum}, exp);
      check($sformatf("%s/hold_rdy%0d", tag, k), sif4.in_ready, 0);
      check($sformatf("%s/hold_vld%0d", tag, k), sif4.out_valid, 1);
    end
    // in_valid is high on the handshake edge; it must not be accepted there.
    sif4.in_valid  = 1'b1;
    sif4.out_ready = 1'b1;
    @(posedge clk); #1;
    sif4.out_ready = 1'b0;
    check({tag, "/post_rdy"}, sif4.in_ready, 1);
    check({tag, "/post_vld"}, sif4.out_valid, 0);
    check({tag, "/post_busy"}, sif4.busy, 0);
    sif4.in_valid = 1'b0;
  endtask

  logic [33:0] q4[$];
  logic [17:0] q2[$];
  int          acc4, acc2, done4, done2, cyc;
  logic [31:0] ra, rb;
  logic        rc;

  initial begin
    rst_n          = 1'b0;
    sif4.in_valid  = 1'b0;
    sif4.a         = '0;
    sif4.b         = '0;
    sif4.cin       = 1'b0;
    sif4.out_ready = 1'b0;
    sif2.in_valid  = 1'b0;
    sif2.a         = '0;
    sif2.b         = '0;
    sif2.cin       = 1'b0;
    sif2.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst/out_valid", sif4.out_valid, 0);
    check("rst/busy", sif4.busy, 0);
    check("rst/result", {sif4.cout, sif4.ovf, sif4.sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst/in_ready", sif4.in_ready, 1);

    // First edge after release accepts; byte carry case.
    do_op4("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0,
           {1'b0, 1'b0, 32'h0000_0100}, 0);
    do_op4("full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1,
           {1'b1, 1'b0, 32'h0000_0000}, 0);
    do_op4("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
           {1'b0, 1'b1, 32'h8000_0000}, 1);
    do_op4("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0,
           {1'b1, 1'b1, 32'h0000_0000}, 0);
    do_op4("backpressure", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1,
           {1'b0, 1'b0, 32'hACF1_3569}, 5);

    // Reset after two ADD cycles abandons the operation.
    sif4.a        = 32'h1122_3344;
    sif4.b        = 32'h0101_0101;
    sif4.cin      = 1'b1;
    sif4.in_valid = 1'b1;
    @(posedge clk); #1;
    sif4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", sif4.out_valid, 0);
    check("midrst/busy", sif4.busy, 0);
    check("midrst/result", {sif4.cout, sif4.ovf, sif4.sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst/in_ready", sif4.in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("midrst/no_result%0d", k), sif4.out_valid, 0);
      @(posedge clk); #1;
    end
    ra = $urandom;
    rb = $urandom;
    rc = 1'($urandom_range(0, 1));
    do_op4("after_rst", ra, rb, rc, ref4(ra, rb, rc), 2);

    // Random soak on both widths with random valid/ready stalls.
    acc4 = 0; acc2 = 0; done4 = 0; done2 = 0; cyc = 0;
    while ((done4 < 1000 || done2 < 1000) && cyc < 40000) begin
      sif4.a         = $urandom;
      sif4.b         = $urandom;
      sif4.cin       = 1'($urandom_range(0, 1));
      sif4.in_valid  = (acc4 < 1000) && ($urandom_range(0, 1) == 1);
      sif4.out_ready = ($urandom_range(0, 3) != 0);
      sif2.a         = 16'($urandom);
      sif2.b         = 16'($urandom);
      sif2.cin       = 1'($urandom_range(0, 1));
      sif2.in_valid  = (acc2 < 1000) && ($urandom_range(0, 1) == 1);
      sif2.out_ready = ($urandom_range(0, 3) != 0);

      if (sif4.out_valid && sif4.out_ready) begin
        if (q4.size() == 0) begin
          check("soak4/spurious_valid", sif4.out_valid, 0);
        end else begin
          check($sformatf("soak4/result%0d", done4),
                {sif4.cout, sif4.ovf, sif4.sum}, q4.pop_front());
          done4++;
        end
      end
      if (sif4.in_valid && sif4.in_ready) begin
        q4.push_back(ref4(sif4.a, sif4.b, sif4.cin));
        acc4++;
        check("soak4/outstanding", q4.size(), 1);
      end

      if (sif2.out_valid && sif2.out_ready) begin
        if (q2.size() == 0) begin
          check("soak2/spurious_valid", sif2.out_valid, 0);
        end else begin
          check($sformatf("soak2/result%0d", done2),
                {sif2.cout, sif2.ovf, sif2.sum}, q2.pop_front());
          done2++;
        end
      end
      if (sif2.in_valid && sif2.in_ready) begin
        q2.push_back(ref2(sif2.a, sif2.b, sif2.cin));
        acc2++;
        check("soak2/outstanding", q2.size(), 1);
      end

      @(posedge clk); #1;
      cyc++;
    end
    sif4.in_valid = 1'b0;
    sif2.in_valid = 1'b0;
    check("soak/in_time", cyc < 40000, 1);
    check("soak4/delivered", done4, 1000);
    check("soak2/delivered", done2, 1000);
    check("soak4/drained", q4.size(), 0);
    check("soak2/drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
